// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM state encoding, the reset NOP word and the RV32 field positions.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam int unsigned OP_LSB     = 0;
    localparam int unsigned OP_MSB     = 6;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned FUNC7_LSB  = 25;
    localparam int unsigned FUNC7_MSB  = 31;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a req/rsp
// handshake and presents it to decode. Optional FETCH_ALIGN_CHECK_EN traps misaligned redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            misalign_err
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic            retire;
    logic            rsp_take;
    logic            redirect_bad;

    // The presented instruction is valid exactly while the FSM sits in HOLD.
    assign retire   = (state == HOLD) && instr_ready;
    assign rsp_take = (state == WAIT) && imem_rsp_valid;
    assign next_pc  = (pc_src ? pc_target : pc_plus4) & ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_bad = retire && pc_src && (pc_target[1:0] != 2'b00);
`else
    assign redirect_bad = 1'b0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        unique case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_next = WAIT;
            end
            WAIT:  if (imem_rsp_valid) state_next = HOLD;
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) state_next = redirect_bad ? ERR : FETCH;
            end
            ERR:   state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_q     <= RESET_PC;
        end else begin
            if (rsp_take) begin
                instr_q <= imem_rsp_data;
                pc_q    <= fetch_pc;
            end
            if (retire) fetch_pc <= next_pc;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)             misalign_err <= 1'b0;
        else if (redirect_bad) misalign_err <= 1'b1;
    end
`endif

    assign imem_addr = fetch_pc;
    assign instr     = instr_q;
    assign op        = instr_q[OP_MSB:OP_LSB];
    assign funct3    = instr_q[FUNCT3_MSB:FUNCT3_LSB];
    assign func7     = instr_q[FUNC7_MSB:FUNC7_LSB];
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; inputs change and outputs are
// sampled on the falling edge. Honours FETCH_ALIGN_CHECK_EN for the misaligned-redirect case.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src;
    logic [31:0] pc_target;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .op             (op),
        .funct3         (funct3),
        .func7          (func7),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pc_src         (pc_src),
        .pc_target      (pc_target)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Wait for a request, optionally stall it (with stray rsp/retire inputs that must be
    // ignored), accept it, return data one cycle later and check the presented instruction.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data,
                         input int stall, input bit junk);
        int n = 0;
        while (!imem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req_valid}, 32'd1);
        check("req_addr", imem_addr, exp_addr);
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                instr_ready    = 1'b1;
                pc_src         = 1'b1;
                pc_target      = 32'h0000_0080;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            check("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_addr, exp_addr);
        end
        instr_ready    = 1'b0;
        pc_src         = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_req", {31'd0, imem_req_valid}, 32'd0);
        check("wait_ivalid", {31'd0, instr_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("hold_ivalid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, data);
        check("hold_pc", pc, exp_addr);
    endtask

    task automatic retire(input logic src, input logic [31:0] target);
        instr_ready = 1'b1;
        pc_src      = src;
        pc_target   = target;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        check("retire_ivalid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        pc_src         = 1'b0;
        pc_target      = '0;
        repeat (2) @(negedge clk);

        check("rst_req", {31'd0, imem_req_valid}, 32'd0);
        check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_op", {25'd0, op}, 32'h13);
        check("rst_funct3", {29'd0, funct3}, 32'd0);
        check("rst_func7", {25'd0, func7}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        reset = 1'b0;

        // addi at 0, then hold with instr_ready low and a stray response
        serve(32'h0, 32'h00A3_0293, 0, 1'b0);
        check("addi_op", {25'd0, op}, 32'h13);
        check("addi_funct3", {29'd0, funct3}, 32'd0);
        check("addi_pc4", pc_plus4, 32'h4);
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            check("hold_instr_stable", instr, 32'h00A3_0293);
            check("hold_op_stable", {25'd0, op}, 32'h13);
            check("hold_pc_stable", pc, 32'h0);
            check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b0;
        retire(1'b0, 32'h0);

        // sub at 4: op=33, func7=20
        serve(32'h4, 32'h40B5_0533, 0, 1'b0);
        check("sub_op", {25'd0, op}, 32'h33);
        check("sub_func7", {25'd0, func7}, 32'h20);
        retire(1'b0, 32'h0);

        // sw at 8 with a 5-cycle stall and ignored stray inputs
        serve(32'h8, 32'h0020_A023, 5, 1'b1);
        check("sw_op", {25'd0, op}, 32'h23);
        check("sw_funct3", {29'd0, funct3}, 32'd2);
        retire(1'b1, 32'h0000_0040);

        serve(32'h40, 32'h0000_0013, 0, 1'b0);
        retire(1'b0, 32'h0);
        serve(32'h44, 32'h0000_0013, 0, 1'b0);

        // wrap-around at the top of the address space
        retire(1'b1, 32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b0);
        check("wrap_pc4", pc_plus4, 32'h0);
        retire(1'b0, 32'h0);
        serve(32'h0, 32'h0000_0013, 0, 1'b0);

        // misaligned redirect
        retire(1'b1, 32'h0000_0042);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_set", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("err_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("err_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("misalign_clr", {31'd0, misalign_err}, 32'd0);
        serve(32'h0, 32'h0000_0013, 0, 1'b0);
        retire(1'b0, 32'h0);
`else
        serve(32'h40, 32'h0000_0013, 0, 1'b0);
        retire(1'b0, 32'h0);
`endif

        // reset pulsed in WAIT; the late response must be dropped
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("pre_rst_wait", {31'd0, imem_req_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("late_ivalid", {31'd0, instr_valid}, 32'd0);
        check("late_instr", instr, 32'h0000_0013);
        check("late_pc", pc, 32'h0);
        serve(32'h0, 32'h0010_0093, 0, 1'b0);
        check("after_rst_op", {25'd0, op}, 32'h13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
